// File: rtl/multiport_register_bank_pkg.sv
// Shared definitions for the multiport register bank:
// dump state encoding and default parameter constants.
package multiport_register_bank_pkg;

  localparam int NB_DATA_DEF     = 32;
  localparam int NB_ADDRESS_DEF  = 5;
  localparam int N_REGISTERS_DEF = 32;

  typedef enum logic [1:0] {
    DUMP_IDLE   = 2'd0,
    DUMP_STREAM = 2'd1,
    DUMP_DONE   = 2'd2
  } dump_state_e;

endpackage

// File: rtl/register_bank_dump_fsm.sv
// Dump sequencer: walks beat index 0..N_REGISTERS-1 under a
// valid/ready handshake, then pulses done for one cycle.
// Ports: i_clk, i_reset (async, active-high), i_start, i_ready,
//        o_valid, o_addr (beat index), o_busy, o_done.
module register_bank_dump_fsm
  import multiport_register_bank_pkg::*;
#(
  parameter int NB_ADDRESS  = NB_ADDRESS_DEF,
  parameter int N_REGISTERS = N_REGISTERS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [NB_ADDRESS-1:0] o_addr,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [NB_ADDRESS-1:0] LAST_IDX =
    NB_ADDRESS'(N_REGISTERS - 1);

  dump_state_e           state_q, state_d;
  logic [NB_ADDRESS-1:0] idx_q, idx_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    unique case (state_q)
      DUMP_IDLE: begin
        if (i_start) begin
          state_d = DUMP_STREAM;
          idx_d   = '0;
        end
      end
      DUMP_STREAM: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        if (i_ready) begin
          // Index returns to 0 so o_addr reads 0 outside STREAM.
          if (idx_q == LAST_IDX) begin
            state_d = DUMP_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DUMP_DONE: begin
        o_done  = 1'b1;
        state_d = DUMP_IDLE;
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  assign o_addr = idx_q;

endmodule

// File: rtl/multiport_register_bank.sv
// Register bank: one write port, two combinational read ports
// with write-to-read forwarding, register 0 hardwired to zero.
// Optional register dump stream when MULTIPORT_REGISTER_BANK_DUMP_EN
// is defined; otherwise dump inputs are ignored, outputs tied to 0.
// Ports: i_clk, i_reset (async, active-high), i_we/i_dr_addr/
//        i_dr_data (write), i_srN_addr/o_srN_data (reads),
//        i_dump_start, i_dump_ready, o_dump_valid/addr/data/
//        busy/done (dump stream).
module multiport_register_bank
  import multiport_register_bank_pkg::*;
#(
  parameter int NB_DATA     = NB_DATA_DEF,
  parameter int NB_ADDRESS  = NB_ADDRESS_DEF,
  parameter int N_REGISTERS = N_REGISTERS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [NB_ADDRESS-1:0] i_dr_addr,
  input  logic [NB_DATA-1:0]    i_dr_data,
  input  logic [NB_ADDRESS-1:0] i_sr1_addr,
  input  logic [NB_ADDRESS-1:0] i_sr2_addr,
  output logic [NB_DATA-1:0]    o_sr1_data,
  output logic [NB_DATA-1:0]    o_sr2_data,
  input  logic                  i_dump_start,
  input  logic                  i_dump_ready,
  output logic                  o_dump_valid,
  output logic [NB_ADDRESS-1:0] o_dump_addr,
  output logic [NB_DATA-1:0]    o_dump_data,
  output logic                  o_dump_busy,
  output logic                  o_dump_done
);

  logic [NB_DATA-1:0] regs_q [N_REGISTERS];
  logic [NB_DATA-1:0] regs_d [N_REGISTERS];
  logic               wr_en;

  // Nonzero and inside the implemented register range.
  function automatic logic writable(
    input logic [NB_ADDRESS-1:0] a
  );
    return (a != '0) && (32'(a) < N_REGISTERS);
  endfunction

  // Read with forwarding of the same-cycle write.
  function automatic logic [NB_DATA-1:0] read_port(
    input logic [NB_ADDRESS-1:0] a
  );
    if (!writable(a)) return '0;
    if (wr_en && (a == i_dr_addr)) return i_dr_data;
    return regs_q[a];
  endfunction

  assign wr_en = i_we && writable(i_dr_addr);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[i_dr_addr] = i_dr_data;
    regs_d[0] = '0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) regs_q <= '{default: '0};
    else         regs_q <= regs_d;
  end

  always_comb o_sr1_data = read_port(i_sr1_addr);
  always_comb o_sr2_data = read_port(i_sr2_addr);

`ifdef MULTIPORT_REGISTER_BANK_DUMP_EN
  register_bank_dump_fsm #(
    .NB_ADDRESS  (NB_ADDRESS),
    .N_REGISTERS (N_REGISTERS)
  ) u_dump_fsm (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_dump_start),
    .i_ready (i_dump_ready),
    .o_valid (o_dump_valid),
    .o_addr  (o_dump_addr),
    .o_busy  (o_dump_busy),
    .o_done  (o_dump_done)
  );

  // Third read port; follows writes so held beats stay current.
  always_comb
    o_dump_data = o_dump_valid ? read_port(o_dump_addr) : '0;
`else
  logic unused_dump;
  assign unused_dump  = i_dump_start ^ i_dump_ready;
  assign o_dump_valid = 1'b0;
  assign o_dump_addr  = '0;
  assign o_dump_data  = '0;
  assign o_dump_busy  = 1'b0;
  assign o_dump_done  = 1'b0;
`endif

endmodule

// File: tb/tb_multiport_register_bank.sv
// Self-checking bench for multiport_register_bank: behavioural
// model of storage and dump sequence, randomized stimulus.
module tb_multiport_register_bank;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we;
  logic [4:0]  dr_addr, sr1_addr, sr2_addr;
  logic [31:0] dr_data;
  logic        dump_start, dump_ready;
  logic [31:0] o_sr1_data, o_sr2_data, o_dump_data;
  logic        o_dump_valid, o_dump_busy, o_dump_done;
  logic [4:0]  o_dump_addr;

  always #5 clk = ~clk;

  multiport_register_bank dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_we         (we),
    .i_dr_addr    (dr_addr),
    .i_dr_data    (dr_data),
    .i_sr1_addr   (sr1_addr),
    .i_sr2_addr   (sr2_addr),
    .o_sr1_data   (o_sr1_data),
    .o_sr2_data   (o_sr2_data),
    .i_dump_start (dump_start),
    .i_dump_ready (dump_ready),
    .o_dump_valid (o_dump_valid),
    .o_dump_addr  (o_dump_addr),
    .o_dump_data  (o_dump_data),
    .o_dump_busy  (o_dump_busy),
    .o_dump_done  (o_dump_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: register contents plus dump phase (0 idle,1 stream,2 done)
  logic [31:0] mem [NR];
  logic [31:0] cap [NR];
  int m_phase, m_idx, beats, dones;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input int a);
    if (a == 0) return 32'h0;
    if (we && int'(dr_addr) == a) return dr_data;
    return mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) mem[i] = 32'h0;
    m_phase = 0;
    m_idx   = 0;
  endtask

  // Compare process: every cycle, mid-period, inputs stable.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sr1", o_sr1_data, exp_read(int'(sr1_addr)));
      chk("sr2", o_sr2_data, exp_read(int'(sr2_addr)));
`ifdef MULTIPORT_REGISTER_BANK_DUMP_EN
      chk("dump_valid", 32'(o_dump_valid), 32'(m_phase == 1));
      chk("dump_busy", 32'(o_dump_busy), 32'(m_phase == 1));
      chk("dump_done", 32'(o_dump_done), 32'(m_phase == 2));
      chk("dump_addr", 32'(o_dump_addr),
          (m_phase == 1) ? 32'(m_idx) : 32'h0);
      chk("dump_data", o_dump_data,
          (m_phase == 1) ? exp_read(m_idx) : 32'h0);
      if (m_phase == 1) begin
        if (dump_ready) begin
          cap[m_idx] = o_dump_data;
          beats++;
          if (m_idx == NR - 1) m_phase = 2;
          else m_idx++;
        end
      end else if (m_phase == 2) begin
        dones++;
        m_phase = 0;
      end else if (dump_start) begin
        m_phase = 1;
        m_idx   = 0;
      end
`else
      chk("dump_valid", 32'(o_dump_valid), 32'h0);
      chk("dump_busy", 32'(o_dump_busy), 32'h0);
      chk("dump_done", 32'(o_dump_done), 32'h0);
      chk("dump_addr", 32'(o_dump_addr), 32'h0);
      chk("dump_data", o_dump_data, 32'h0);
`endif
      if (we && dr_addr != 5'd0) mem[dr_addr] = dr_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    we = 0; dr_addr = 0; dr_data = 0;
    sr1_addr = 5; sr2_addr = 0;
    dump_start = 0; dump_ready = 0;
    beats = 0; dones = 0;
    model_clear();
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 32'(o_dump_valid), 32'h0);
    chk("rst_busy", 32'(o_dump_busy), 32'h0);
    chk("rst_done", 32'(o_dump_done), 32'h0);
    chk("rst_addr", 32'(o_dump_addr), 32'h0);
    chk("rst_r5", o_sr1_data, 32'h0);
    cyc(); cyc();
    rst = 1'b0;
    chk_en = 1'b1;

    // Basic write then read
    we = 1; dr_addr = 5; dr_data = 32'hDEADBEEF;
    sr1_addr = 5; sr2_addr = 6;
    cyc();
    we = 0;
    #1;
    chk("r5_read", o_sr1_data, 32'hDEADBEEF);
    chk("r6_read", o_sr2_data, 32'h0);

    // Writes to r0 are discarded
    we = 1; dr_addr = 0; dr_data = 32'h12345678; sr1_addr = 0;
    #1 chk("r0_fwd", o_sr1_data, 32'h0);
    cyc();
    we = 0;
    #1 chk("r0_read", o_sr1_data, 32'h0);

    // Same-cycle forwarding on both ports
    we = 1; dr_addr = 7; dr_data = 32'hA5A5A5A5;
    sr1_addr = 7; sr2_addr = 7;
    #1;
    chk("fwd_sr1", o_sr1_data, 32'hA5A5A5A5);
    chk("fwd_sr2", o_sr2_data, 32'hA5A5A5A5);
    cyc();
    we = 0;
    #1 chk("r7_read", o_sr1_data, 32'hA5A5A5A5);

`ifdef MULTIPORT_REGISTER_BANK_DUMP_EN
    // Random traffic with overlapping dumps
    repeat (400) begin
      cyc();
      we = 1'($urandom_range(0, 1));
      dr_addr = 5'($urandom);
      dr_data = $urandom;
      sr1_addr = 5'($urandom);
      sr2_addr = 5'($urandom);
      dump_start = ($urandom_range(0, 15) == 0);
      dump_ready = 1'($urandom_range(0, 1));
    end
    we = 0; dump_start = 0; dump_ready = 1;
    for (int c = 0; c < 100 && m_phase != 0; c++) cyc();
    chk("drain_idle", 32'(m_phase), 32'h0);

    // Known contents, ready toggling
    for (int k = 1; k < NR; k++) begin
      cyc();
      we = 1; dr_addr = 5'(k); dr_data = 32'(k + 32'h100);
    end
    cyc();
    we = 0; beats = 0; dones = 0;
    dump_start = 1; dump_ready = 1;
    cyc();
    dump_start = 0;
    for (int c = 0; c < 200 && dones == 0; c++) begin
      cyc();
      dump_ready = ~dump_ready;
    end
    repeat (5) cyc();
    chk("dump_beats", 32'(beats), 32'd32);
    chk("dump_dones", 32'(dones), 32'd1);
    for (int k = 0; k < NR; k++)
      chk("dump_cap", cap[k], (k == 0) ? 32'h0 : 32'(k + 32'h100));

    // Reset mid-dump
    dones = 0; dump_ready = 1; dump_start = 1;
    cyc();
    dump_start = 0;
    for (int c = 0; c < 100; c++) begin
      if (o_dump_valid && o_dump_addr == 5'd10) break;
      cyc();
    end
    chk("beat10_reached", 32'(o_dump_addr), 32'd10);
    rst = 1'b1;
    model_clear();
    #1;
    chk("abort_valid", 32'(o_dump_valid), 32'h0);
    chk("abort_busy", 32'(o_dump_busy), 32'h0);
    for (int a = 0; a < NR; a++) begin
      sr1_addr = 5'(a);
      sr2_addr = 5'(NR - 1 - a);
      #1 chk("abort_clear", o_sr1_data, 32'h0);
      cyc();
    end
    rst = 1'b0;
    repeat (10) cyc();
    chk("abort_no_done", 32'(dones), 32'h0);
`else
    dump_start = 1; dump_ready = 1;
    cyc();
    dump_start = 0;
    repeat (40) begin
      cyc();
      we = 1'($urandom_range(0, 1));
      dr_addr = 5'($urandom);
      dr_data = $urandom;
      sr1_addr = 5'($urandom);
      sr2_addr = 5'($urandom);
    end
    we = 0;
    #1;
    chk("nodump_valid", 32'(o_dump_valid), 32'h0);
    chk("nodump_busy", 32'(o_dump_busy), 32'h0);
    chk("nodump_done", 32'(o_dump_done), 32'h0);
`endif

    cyc();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
